ncl_gate_sequencer: RTL and testbench

Synchronous wavefront sequencer for a dual-rail NULL-convention gate under test (the 2-input dual-rail NAND fabric cell driven through FPGA pins). It drives the four operand rails through alternating NULL and DATA wavefronts for all four operand combinations. It waits for completion on the two returned output rails and checks each result against NAND. It also counts passes, errors, illegal codewords and timeouts for LED/host readout.

---
 rtl/ncl_gate_sequencer_if.sv | 28 ++
 rtl/ncl_gate_sequencer.sv | 133 +++++++++++++
 tb/tb_ncl_gate_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncl_gate_sequencer_if.sv
// Pin-level bundle between the wavefront sequencer and the dual-rail gate under test.
// The master side is the host/gate harness; the slave side is the sequencer.
interface ncl_gate_sequencer_if;
  logic        start;
  logic        loop;
  logic        o0;
  logic        o1;
  logic        x0;
  logic        x1;
  logic        y0;
  logic        y1;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  last_result;
  logic [15:0] pass_cnt;
  logic [15:0] err_cnt;

  modport master (
    output start, loop, o0, o1,
    input  x0, x1, y0, y1, busy, done, fault, last_result, pass_cnt, err_cnt
  );

  modport slave (
    input  start, loop, o0, o1,
    output x0, x1, y0, y1, busy, done, fault, last_result, pass_cnt, err_cnt
  );
endinterface

// File: rtl/ncl_gate_sequencer.sv
// Drives a dual-rail NAND cell through NULL/DATA wavefronts for all four operand
// pairs, checks completions against NAND and keeps saturating pass/error counters.
module ncl_gate_sequencer #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ncl_gate_sequencer_if.slave   bus
);
  typedef enum logic [2:0] {S_IDLE, S_NULL, S_DATA, S_CHECK, S_DONE} state_t;

  state_t      r_state, w_nstate;
  logic        r_s0_m, r_s1_m, r_s0, r_s1;
  logic [1:0]  r_prev, r_v, r_cap, r_last;
  logic [3:0]  r_stab;
  logic [7:0]  r_wait;
  logic        r_ill_seen;
  logic        r_x0, r_x1, r_y0, r_y1, r_busy, r_done, r_fault;
  logic [15:0] r_pass, r_err;

  logic [1:0]  w_s, w_exp, w_err_inc;
  logic [3:0]  w_stab_nx;
  logic [3:0]  w_rails_d;
  logic [16:0] w_err_sum;
  logic        w_wait, w_cond, w_settled, w_timeout, w_illegal;
  logic        w_ill_evt, w_to_evt, w_mis, w_pass_inc, w_adv;
  logic        w_busy_d, w_done_d;

  assign w_s       = {r_s1, r_s0};
  assign w_wait    = (r_state == S_NULL) || (r_state == S_DATA);
  assign w_illegal = w_wait && r_s0 && r_s1;
  assign w_cond    = (r_state == S_NULL) ? (w_s == 2'b00) :
                     (r_state == S_DATA) ? (r_s0 ^ r_s1) : 1'b0;
  // Run length restarts whenever the sampled codeword changes, so DATA completion
  // requires the same rail for all SETTLE cycles.
  assign w_stab_nx = !w_cond ? 4'd0 :
                     (r_stab != 4'd0 && w_s == r_prev) ? r_stab + 4'd1 : 4'd1;
  assign w_settled = w_cond && (w_stab_nx >= 4'(SETTLE));
  assign w_timeout = w_wait && (r_wait == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state logic
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nstate = S_NULL;
      S_NULL:  if (w_settled || w_timeout) w_nstate = S_DATA;
      S_DATA: begin
        if (w_settled)      w_nstate = S_CHECK;
        else if (w_timeout) w_nstate = (r_v == 2'b11) ? S_DONE : S_NULL;
      end
      S_CHECK: w_nstate = (r_v == 2'b11) ? S_DONE : S_NULL;
      S_DONE:  w_nstate = bus.loop ? S_NULL : S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    w_exp      = {~(r_v[1] & r_v[0]), r_v[1] & r_v[0]};
    w_pass_inc = (r_state == S_CHECK) && (r_cap == w_exp);
    w_mis      = (r_state == S_CHECK) && (r_cap != w_exp);
    w_ill_evt  = w_illegal && !r_ill_seen;
    w_to_evt   = w_timeout && !w_settled;
    w_err_inc  = 2'(w_mis) + 2'(w_ill_evt) + 2'(w_to_evt);
    w_adv      = (r_state == S_CHECK) || ((r_state == S_DATA) && w_to_evt);
    // Operands stay on the rails through CHECK so NULL starts cleanly on NULL_WAIT entry.
    if (w_nstate == S_DATA || w_nstate == S_CHECK)
      w_rails_d = {~r_v[1], r_v[1], ~r_v[0], r_v[0]};
    else
      w_rails_d = 4'b0000;
    w_busy_d   = (w_nstate != S_IDLE);
    w_done_d   = (w_nstate == S_DONE);
  end

  assign w_err_sum = {1'b0, r_err} + 17'(w_err_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_m <= 1'b0; r_s1_m <= 1'b0; r_s0 <= 1'b0; r_s1 <= 1'b0;
      r_prev <= 2'b00; r_stab <= 4'd0; r_wait <= 8'd0; r_ill_seen <= 1'b0;
      r_v <= 2'b00; r_cap <= 2'b00; r_last <= 2'b00;
      {r_x0, r_x1, r_y0, r_y1} <= 4'b0000;
      r_busy <= 1'b0; r_done <= 1'b0; r_fault <= 1'b0;
      r_pass <= 16'd0; r_err <= 16'd0;
    end else begin
      r_s0_m <= bus.o0; r_s0 <= r_s0_m;
      r_s1_m <= bus.o1; r_s1 <= r_s1_m;
      r_prev <= w_s;

      if (w_nstate != r_state) begin
        r_stab     <= 4'd0;
        r_wait     <= 8'd0;
        r_ill_seen <= 1'b0;
      end else begin
        r_stab <= w_stab_nx;
        if (w_wait)    r_wait     <= r_wait + 8'd1;
        if (w_illegal) r_ill_seen <= 1'b1;
      end

      if (r_state == S_IDLE || r_state == S_DONE) r_v <= 2'b00;
      else if (w_adv && r_v != 2'b11)              r_v <= r_v + 2'd1;

      if (r_state == S_DATA && w_settled) r_cap  <= w_s;
      if (r_state == S_CHECK)             r_last <= r_cap;

      {r_x0, r_x1, r_y0, r_y1} <= w_rails_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;

      if (w_pass_inc && r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
      r_err   <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
      r_fault <= r_fault | (w_err_inc != 2'd0);
    end
  end

  assign bus.x0          = r_x0;
  assign bus.x1          = r_x1;
  assign bus.y0          = r_y0;
  assign bus.y1          = r_y1;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.fault       = r_fault;
  assign bus.last_result = r_last;
  assign bus.pass_cnt    = r_pass;
  assign bus.err_cnt     = r_err;
endmodule

// File: tb/tb_ncl_gate_sequencer.sv
// Directed bench: a 2-cycle dual-rail NAND model with injectable faults answers the sequencer.
module tb_ncl_gate_sequencer;
  localparam int STUCK_REL = 253;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mode = 0;

  ncl_gate_sequencer_if bus();

  ncl_gate_sequencer #(.SETTLE(2), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Gate model: mode 1 swaps rails on vector 10, mode 2 holds o1 high through NULL
  // (released just before the sequencer gives up), mode 3 emits 11 for 3 cycles on vector 01.
  logic [3:0] rails;
  logic [1:0] g_ideal, g_nxt;
  logic [1:0] p1 = 2'b00;
  logic [1:0] p2 = 2'b00;
  int         ill_cnt = 0;
  int         null_cnt = 0;
  logic       stuck;

  assign rails   = {bus.x1, bus.x0, bus.y1, bus.y0};
  assign g_ideal = {bus.x0 | bus.y0, bus.x1 & bus.y1};
  assign stuck   = (mode == 2) && (rails == 4'b0000) && (null_cnt < STUCK_REL);
  assign bus.o1  = p2[1] | stuck;
  assign bus.o0  = p2[0];

  always_comb begin
    g_nxt = g_ideal;
    if (mode == 1 && bus.x1 && bus.y0)
      g_nxt = {g_ideal[0], g_ideal[1]};
    else if (mode == 3 && bus.x0 && bus.y1 && ill_cnt < 3)
      g_nxt = 2'b11;
  end

  always @(posedge clk) begin
    p1 <= g_nxt;
    p2 <= p1;
    if (mode != 3) ill_cnt <= 0;
    else if (bus.x0 && bus.y1 && ill_cnt < 3) ill_cnt <= ill_cnt + 1;
    null_cnt <= (rails != 4'b0000 || !bus.busy) ? 0 : null_cnt + 1;
  end

  // Monitor: log each DATA wavefront as {a,b} and count done pulses.
  logic [1:0] vlog[$];
  logic       prev_null = 1'b1;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (rails != 4'b0000 && prev_null) vlog.push_back({bus.x1, bus.y1});
    prev_null <= (rails == 4'b0000);
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rails !== 4'b0000) begin errors++; $display("FAIL reset_rails got=%b exp=0000", rails); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
    checks++; if (bus.last_result !== 2'b00) begin errors++; $display("FAIL reset_last got=%b exp=00", bus.last_result); end
    checks++; if (bus.pass_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.pass_cnt, bus.err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    int base, vbase;
    bit ok;
    mode = 0;
    apply_reset();
    base = done_cnt; vbase = vlog.size();
    pulse_start();
    checks++; if (bus.busy !== 1'b1 || rails !== 4'b0000) begin
      errors++; $display("FAIL ideal_accept busy=%b rails=%b exp busy=1 rails=0000", bus.busy, rails);
    end
    wait_done(base + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ideal_done_timeout got=0 exp=1"); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL ideal_done_pulses got=%0d exp=1", done_cnt - base); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ideal_idle busy=%b exp=0", bus.busy); end
    checks++; if (bus.pass_cnt !== 16'd4) begin errors++; $display("FAIL ideal_pass got=%0d exp=4", bus.pass_cnt); end
    checks++; if (bus.err_cnt !== 16'd0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL ideal_err got=%0d fault=%b exp=0 fault=0", bus.err_cnt, bus.fault);
    end
    checks++; if (bus.last_result !== 2'b01) begin errors++; $display("FAIL ideal_last got=%b exp=01", bus.last_result); end
    checks++; if (vlog.size() !== vbase + 4) begin
      errors++; $display("FAIL ideal_vec_count got=%0d exp=4", vlog.size() - vbase);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (vlog[vbase + i] !== 2'(i)) begin
          errors++; $display("FAIL ideal_vec_order idx=%0d got=%b exp=%b", i, vlog[vbase + i], 2'(i));
        end
      end
    end
  endtask

  task automatic test_swap();
    int base;
    bit ok;
    mode = 1;
    apply_reset();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 400, ok);
    #20;
    checks++; if (!ok) begin errors++; $display("FAIL swap_done_timeout got=0 exp=1"); end
    checks++; if (bus.pass_cnt !== 16'd3 || bus.err_cnt !== 16'd1) begin
      errors++; $display("FAIL swap_counts got=%0d/%0d exp=3/1", bus.pass_cnt, bus.err_cnt);
    end
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL swap_fault got=%b exp=1", bus.fault); end
    // A clean pass afterwards must leave fault set.
    mode = 0;
    pulse_start();
    wait_done(base + 2, 400, ok);
    #20;
    checks++; if (bus.fault !== 1'b1 || bus.pass_cnt !== 16'd7 || bus.err_cnt !== 16'd1) begin
      errors++; $display("FAIL swap_sticky fault=%b pass=%0d err=%0d exp fault=1 pass=7 err=1",
                         bus.fault, bus.pass_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_timeout();
    int base;
    bit ok;
    mode = 2;
    apply_reset();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 3000, ok);
    #20;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done_timeout got=0 exp=1"); end
    checks++; if (bus.pass_cnt !== 16'd4 || bus.err_cnt !== 16'd4) begin
      errors++; $display("FAIL timeout_counts got=%0d/%0d exp=4/4", bus.pass_cnt, bus.err_cnt);
    end
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got=%b exp=1", bus.fault); end
    mode = 0;
  endtask

  task automatic test_illegal();
    int base;
    bit ok;
    mode = 3;
    apply_reset();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 400, ok);
    #20;
    checks++; if (!ok) begin errors++; $display("FAIL illegal_done_timeout got=0 exp=1"); end
    checks++; if (bus.pass_cnt !== 16'd4 || bus.err_cnt !== 16'd1) begin
      errors++; $display("FAIL illegal_counts got=%0d/%0d exp=4/1", bus.pass_cnt, bus.err_cnt);
    end
    checks++; if (bus.fault !== 1'b1 || bus.last_result !== 2'b01) begin
      errors++; $display("FAIL illegal_fault_last fault=%b last=%b exp fault=1 last=01", bus.fault, bus.last_result);
    end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    int base, vbase;
    bit ok;
    mode = 0;
    apply_reset();
    base = done_cnt; vbase = vlog.size();
    bus.loop = 1'b1;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    pulse_start();
    wait_done(base + 2, 800, ok);
    bus.loop = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL loop_two_passes got=0 exp=1"); end
    pulse_start();
    wait_done(base + 3, 800, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_cnt - base !== 3) begin errors++; $display("FAIL loop_done_pulses got=%0d exp=3", done_cnt - base); end
    checks++; if (bus.pass_cnt !== 16'd12 || bus.err_cnt !== 16'd0) begin
      errors++; $display("FAIL loop_counts got=%0d/%0d exp=12/0", bus.pass_cnt, bus.err_cnt);
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL loop_idle busy=%b exp=0", bus.busy); end
    checks++; if (vlog.size() !== vbase + 12) begin
      errors++; $display("FAIL loop_vec_count got=%0d exp=12", vlog.size() - vbase);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++; if (vlog[vbase + i] !== 2'(i % 4)) begin
          errors++; $display("FAIL loop_vec_order idx=%0d got=%b exp=%b", i, vlog[vbase + i], 2'(i % 4));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, vbase;
    bit found, ok;
    mode = 0;
    apply_reset();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (rails == 4'b1001) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_vec10 got=0 exp=1"); end
    checks++; if (bus.pass_cnt !== 16'd2) begin errors++; $display("FAIL rstmid_pre_pass got=%0d exp=2", bus.pass_cnt); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rails !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs rails=%b busy=%b done=%b exp 0000/0/0", rails, bus.busy, bus.done);
    end
    checks++; if (bus.pass_cnt !== 16'd0 || bus.err_cnt !== 16'd0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL rstmid_counters pass=%0d err=%0d fault=%b exp 0/0/0", bus.pass_cnt, bus.err_cnt, bus.fault);
    end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    base = done_cnt; vbase = vlog.size();
    pulse_start();
    wait_done(base + 1, 400, ok);
    #20;
    checks++; if (vlog.size() < vbase + 1 || vlog[vbase] !== 2'b00) begin
      errors++; $display("FAIL rstmid_restart_vec got_entries=%0d exp first=00", vlog.size() - vbase);
    end
    checks++; if (!ok || bus.pass_cnt !== 16'd4) begin
      errors++; $display("FAIL rstmid_repass ok=%0d pass=%0d exp ok=1 pass=4", ok, bus.pass_cnt);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.loop  = 1'b0;
    test_reset();
    test_ideal();
    test_swap();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
